// File: rtl/demux4_bit_1to3_buf_pkg.sv
// Shared definitions for the 1-to-3 buffered demultiplexer.
//   chan_e      : channel index (CH_A=0, CH_B=1, CH_C=2)
//   sel_to_chan : maps the 2-bit destination select onto a channel;
//                 select values 2 and 3 both go to channel C.
package demux4_bit_1to3_buf_pkg;

    typedef enum logic [1:0] {
        CH_A = 2'd0,
        CH_B = 2'd1,
        CH_C = 2'd2
    } chan_e;

    function automatic chan_e sel_to_chan(input logic [1:0] sel);
        case (sel)
            2'd0:    return CH_A;
            2'd1:    return CH_B;
            default: return CH_C;
        endcase
    endfunction

endpackage

// File: rtl/demux4_bit_1to3_buf_chan_fifo.sv
// Per-channel FIFO for the 1-to-3 demultiplexer.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   push  : write din at the tail (ignored when full)
//   pop   : advance the head (ignored when empty)
//   din   : word to write
//   dout  : registered head word; holds its last value while empty
//   count : number of stored words, 0..DEPTH
//   full  : count == DEPTH
//   empty : count == 0
module demux_chan_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    rd_nxt;
    logic             push_ok;
    logic             pop_ok;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] head_nxt;

    // dout is a dedicated register rather than mem[rd_ptr], so that an
    // emptied channel keeps showing its last head word and reset can clear
    // it without clearing the whole array. Its next value is the word that
    // will sit at the head after this cycle's push/pop.
    always_comb begin
        full      = (count == DEPTH_C);
        empty     = (count == '0);
        push_ok   = push & ~full;
        pop_ok    = pop & ~empty;
        rd_nxt    = rd_ptr + 1'b1;
        count_nxt = count + CW'(push_ok) - CW'(pop_ok);
        head_nxt  = dout;
        if (count_nxt != '0) begin
            // Only the incoming word remains: channel was empty, or its
            // single entry is being popped while a new one arrives.
            if (empty || (pop_ok && count == ONE_C)) begin
                head_nxt = din;
            end else if (pop_ok) begin
                head_nxt = mem[rd_nxt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_nxt;
            end
            count <= count_nxt;
            dout  <= head_nxt;
        end
    end

    // Storage needs no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (rst_n && push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/demux4_bit_1to3_buf.sv
// Buffered 1-to-3 demultiplexer: routes each accepted input word into the
// FIFO of the channel chosen by inSel.
//   Clk                  : clock, rising edge
//   Rst                  : synchronous active-low reset
//   inData/inSel/inValid : producer word, destination (0:A 1:B 2,3:C), offer
//   inReady              : selected channel not full (from registered count)
//   outA/outB/outC       : head word of each channel
//   outValidA/B/C        : channel non-empty
//   outReadyA/B/C        : consumer takes the head word
//   busy                 : any channel non-empty
module demux4_bit_1to3_buf
    import demux4_bit_1to3_buf_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] inData,
    input  logic [1:0]       inSel,
    input  logic             inValid,
    output logic             inReady,
    output logic [WIDTH-1:0] outA,
    output logic [WIDTH-1:0] outB,
    output logic [WIDTH-1:0] outC,
    output logic             outValidA,
    output logic             outValidB,
    output logic             outValidC,
    input  logic             outReadyA,
    input  logic             outReadyB,
    input  logic             outReadyC,
    output logic             busy
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    chan_e          ch;
    logic           push_a, push_b, push_c;
    logic [CW-1:0]  cnt_a, cnt_b, cnt_c;
    logic           full_a, full_b, full_c;
    logic           empty_a, empty_b, empty_c;

    always_comb begin
        ch = sel_to_chan(inSel);
        case (ch)
            CH_A:    inReady = ~full_a;
            CH_B:    inReady = ~full_b;
            default: inReady = ~full_c;
        endcase
        push_a    = inValid & inReady & (ch == CH_A);
        push_b    = inValid & inReady & (ch == CH_B);
        push_c    = inValid & inReady & (ch == CH_C);
        outValidA = (cnt_a != '0);
        outValidB = (cnt_b != '0);
        outValidC = (cnt_c != '0);
        busy      = ~(empty_a & empty_b & empty_c);
    end

    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk(Clk), .rst_n(Rst), .push(push_a), .pop(outReadyA),
        .din(inData), .dout(outA), .count(cnt_a), .full(full_a), .empty(empty_a)
    );

    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk(Clk), .rst_n(Rst), .push(push_b), .pop(outReadyB),
        .din(inData), .dout(outB), .count(cnt_b), .full(full_b), .empty(empty_b)
    );

    demux_chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_c (
        .clk(Clk), .rst_n(Rst), .push(push_c), .pop(outReadyC),
        .din(inData), .dout(outC), .count(cnt_c), .full(full_c), .empty(empty_c)
    );

endmodule

// File: tb/tb_demux4_bit_1to3_buf.sv
module tb_demux4_bit_1to3_buf;

    logic       Clk = 1'b0;
    logic       Rst;
    logic [3:0] inData;
    logic [1:0] inSel;
    logic       inValid;
    logic       inReady;
    logic [3:0] outA, outB, outC;
    logic       outValidA, outValidB, outValidC;
    logic       outReadyA, outReadyB, outReadyC;
    logic       busy;

    int unsigned errors = 0;
    int unsigned checks = 0;

    demux4_bit_1to3_buf #(.WIDTH(4), .DEPTH(2)) dut (
        .Clk(Clk), .Rst(Rst),
        .inData(inData), .inSel(inSel), .inValid(inValid), .inReady(inReady),
        .outA(outA), .outB(outB), .outC(outC),
        .outValidA(outValidA), .outValidB(outValidB), .outValidC(outValidC),
        .outReadyA(outReadyA), .outReadyB(outReadyB), .outReadyC(outReadyC),
        .busy(busy)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] sel, input logic [3:0] d);
        inSel   = sel;
        inData  = d;
        inValid = 1'b1;
        tick();
        inValid = 1'b0;
    endtask

    initial begin
        Rst = 1'b0; inData = '0; inSel = '0; inValid = 1'b0;
        outReadyA = 1'b0; outReadyB = 1'b0; outReadyC = 1'b0;

        // Reset
        tick(); tick();
        Rst = 1'b1;
        chk("rst_validA", 32'(outValidA), 0);
        chk("rst_validB", 32'(outValidB), 0);
        chk("rst_validC", 32'(outValidC), 0);
        chk("rst_busy",   32'(busy), 0);
        chk("rst_outA",   32'(outA), 0);
        chk("rst_outB",   32'(outB), 0);
        chk("rst_outC",   32'(outC), 0);
        for (int s = 0; s < 4; s++) begin
            inSel = 2'(s);
            #1;
            chk($sformatf("rst_inReady_sel%0d", s), 32'(inReady), 1);
        end

        // Routing, with single-cycle latency into an empty channel
        push(2'd0, 4'h5);
        chk("lat_validA", 32'(outValidA), 1);
        chk("lat_outA",   32'(outA), 32'h5);
        push(2'd1, 4'hA);
        push(2'd3, 4'h3);
        chk("route_outA", 32'(outA), 32'h5);
        chk("route_outB", 32'(outB), 32'hA);
        chk("route_outC", 32'(outC), 32'h3);
        chk("route_valid", 32'({outValidA, outValidB, outValidC}), 32'b111);
        chk("route_busy", 32'(busy), 1);

        // Drain all; heads hold last value while empty
        outReadyA = 1'b1; outReadyB = 1'b1; outReadyC = 1'b1;
        tick();
        outReadyA = 1'b0; outReadyB = 1'b0; outReadyC = 1'b0;
        chk("drain_valid", 32'({outValidA, outValidB, outValidC}), 0);
        chk("drain_busy", 32'(busy), 0);
        chk("hold_outA", 32'(outA), 32'h5);
        chk("hold_outB", 32'(outB), 32'hA);
        chk("hold_outC", 32'(outC), 32'h3);

        // Full channel B
        push(2'd1, 4'h1);
        push(2'd1, 4'h2);
        inSel = 2'd1; #1;
        chk("full_inReady_B", 32'(inReady), 0);
        inSel = 2'd0; #1;
        chk("full_inReady_A", 32'(inReady), 1);
        push(2'd1, 4'h9);
        chk("full_outB_first", 32'(outB), 32'h1);
        outReadyB = 1'b1;
        tick();
        chk("full_pop1_outB", 32'(outB), 32'h2);
        chk("full_pop1_valid", 32'(outValidB), 1);
        tick();
        outReadyB = 1'b0;
        chk("full_pop2_valid", 32'(outValidB), 0);
        chk("full_pop2_hold", 32'(outB), 32'h2);

        // Concurrent push and pop on B holding one word
        push(2'd1, 4'h7);
        inSel = 2'd1; inData = 4'h8; inValid = 1'b1; outReadyB = 1'b1;
        #1;
        chk("conc_inReady", 32'(inReady), 1);
        tick();
        inValid = 1'b0; outReadyB = 1'b0;
        chk("conc_validB", 32'(outValidB), 1);
        chk("conc_outB", 32'(outB), 32'h8);
        push(2'd1, 4'h4);
        inSel = 2'd1; #1;
        chk("conc_count_full", 32'(inReady), 0);

        // Full plus pop: no ready-through
        inSel = 2'd1; inData = 4'hE; inValid = 1'b1; outReadyB = 1'b1;
        #1;
        chk("fullpop_inReady", 32'(inReady), 0);
        tick();
        inValid = 1'b0;
        chk("fullpop_outB", 32'(outB), 32'h4);
        chk("fullpop_validB", 32'(outValidB), 1);
        tick();
        outReadyB = 1'b0;
        chk("fullpop_empty", 32'(outValidB), 0);

        // Mid-run reset
        push(2'd0, 4'h1);
        push(2'd0, 4'h2);
        push(2'd2, 4'h3);
        push(2'd2, 4'h4);
        chk("mid_pre_valid", 32'({outValidA, outValidB, outValidC}), 32'b101);
        Rst = 1'b0; outReadyA = 1'b1;
        tick();
        Rst = 1'b1; outReadyA = 1'b0;
        chk("mid_valid", 32'({outValidA, outValidB, outValidC}), 0);
        chk("mid_busy", 32'(busy), 0);
        chk("mid_outA", 32'(outA), 0);
        chk("mid_outC", 32'(outC), 0);
        push(2'd0, 4'hF);
        chk("mid_push_outA", 32'(outA), 32'hF);
        chk("mid_push_valid", 32'({outValidA, outValidB, outValidC}), 32'b100);
        outReadyA = 1'b1;
        tick();
        outReadyA = 1'b0;
        chk("mid_alone", 32'(outValidA), 0);
        chk("mid_idle", 32'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux4_bit_1to3_buf.md
DEMUX4_BIT_1TO3_BUF -- requirements
Module: demux4_bit_1to3_buf

Interface
REQ-001 Parameter: WIDTH, 4, data word width in bits.
REQ-002 Parameter: DEPTH, 2, entries per output channel FIFO; power of two, >= 2.
REQ-003 Port: Clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: Rst  input  1  reset, synchronous, active-low.
REQ-005 Port: inData  input  WIDTH  word to distribute.
REQ-006 Port: inSel  input  2  destination: 0 -> A, 1 -> B, 2 or 3 -> C.
REQ-007 Port: inValid  input  1  producer offers inData/inSel this cycle.
REQ-008 Port: inReady  output  1  selected channel can accept this cycle.
REQ-009 Ports: outA/outB/outC  output  WIDTH  head word of each channel FIFO.
REQ-010 Ports: outValidA/B/C  output  1  channel FIFO non-empty.
REQ-011 Ports: outReadyA/B/C  input  1  consumer takes head word this cycle.
REQ-012 Port: busy  output  1  any channel FIFO non-empty.

Function
REQ-013 Push: when inValid && inReady, write inData to the tail of the channel selected by inSel.
REQ-014 inReady SHALL be combinational from inSel and the selected channel's registered count only: 1 iff that count < DEPTH.
REQ-015 Full channel: inReady=0 even if that channel pops in the same cycle; no ready-through path.
REQ-016 Push to one channel SHALL NOT depend on the fullness of the other channels.
REQ-017 Pop: when outValidX && outReadyX, advance channel X head; outReadyX while outValidX=0 has no effect.
REQ-018 outValidX = (countX != 0); outX = head entry of X, registered storage, no combinational path from inData.
REQ-019 Latency: a word pushed into an empty channel appears on outX with outValidX=1 the next cycle.
REQ-020 Simultaneous push and pop on the same channel: count unchanged, FIFO order preserved.
REQ-021 Pointers wrap modulo DEPTH; count range 0..DEPTH, width clog2(DEPTH)+1.
REQ-022 Per-channel order is strict FIFO; no ordering guarantee between channels.
REQ-023 outX while outValidX=0 SHALL hold the last head value (no reset of storage required beyond REQ-025).
REQ-024 busy = outValidA | outValidB | outValidC.

Reset
REQ-025 When Rst=0 at a rising edge: all counts and pointers = 0; outValidA/B/C = 0; busy = 0; outA/B/C = 0.
REQ-026 Reset mid-operation discards all buffered words; no pop handshake completes in the reset cycle.
REQ-027 inReady during reset follows REQ-014 with counts 0, and any push in a reset cycle is discarded.

Structure
REQ-028 Shared package holds: channel index constants CH_A=0, CH_B=1, CH_C=2 and the sel-to-channel decode (3 -> CH_C).
REQ-029 One sub-module, demux_chan_fifo (WIDTH, DEPTH; push, pop, data in/out, count, full, empty), instantiated three times.
REQ-030 Top level holds only the sel decode, inReady mux, and busy OR.

Verification
REQ-031 Reset: Rst=0 two cycles, then Rst=1 -> all outValid=0, busy=0, outA/B/C=0, inReady=1 for every inSel.
REQ-032 Routing: push 0x5 sel=0, 0xA sel=1, 0x3 sel=3 with all outReady=0 -> next cycle outA=5, outB=A, outC=3, all outValid=1.
REQ-033 Full: outReadyB=0, push 0x1, 0x2 to B -> inReady=0 for sel=1 while inReady=1 for sel=0; third push not taken; then pop B twice -> 0x1 then 0x2.
REQ-034 Concurrent: B holds 1 word (0x7), push 0x8 to B with outReadyB=1 same cycle -> count stays 1, outB=8 next cycle.
REQ-035 Full plus pop: B full, outReadyB=1 and inValid sel=1 -> inReady=0, count drops to 1, word not accepted.
REQ-036 Mid-run reset: A and C each hold 2 words, Rst=0 one cycle -> all outValid=0 and busy=0 next cycle; subsequent push 0xF to A appears alone.
